// File: rtl/encrypt_seq_if.sv
// Request/result handshake bundle between the host and the iterative cipher.
// The host drives the request side and consumes the result side; the cipher
// block sits on the slave modport.
interface encrypt_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [79:0] K;
    logic [63:0] M;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] C;

    modport master (
        output req_valid, K, M, res_ready,
        input  req_ready, res_valid, C
    );

    modport slave (
        input  req_valid, K, M, res_ready,
        output req_ready, res_valid, C
    );
endinterface

// File: rtl/encrypt_seq.sv
// Iterative 80-bit-key / 64-bit-block cipher sequencer. A single round,
// key-schedule and key-addition datapath is reused for ROUNDS cycles, then
// one final key addition produces the ciphertext, which is held until the
// consumer takes it.
module encrypt_seq #(
    parameter int ROUNDS = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    encrypt_seq_if.slave      bus,
    output logic              busy,
    output logic [4:0]        round_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    // The 5-bit round counter and key-schedule constant only cover 1..31.
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_rounds_check
        $error("encrypt_seq: ROUNDS must be in 1..31");
    end

    // 4-bit substitution box shared by the round and the key schedule.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    logic [1:0]  state;
    logic [63:0] st;
    logic [79:0] ky;
    logic [63:0] c_q;
    logic        res_valid_q;

    // Round datapath: add round key, substitute each nibble, permute bits.
    logic [63:0] ark;
    logic [63:0] sb_out;
    logic [63:0] st_next;

    assign ark = st ^ ky[79:16];

    for (genvar n = 0; n < 16; n++) begin : g_sbox
        assign sb_out[4*n +: 4] = sbox(ark[4*n +: 4]);
    end

    // Bit i moves to position 16*i mod 63; the top bit stays in place.
    for (genvar i = 0; i < 63; i++) begin : g_perm
        assign st_next[(i*16) % 63] = sb_out[i];
    end
    assign st_next[63] = sb_out[63];

    // Key schedule: rotate left by 61, substitute the top nibble, and fold
    // the round counter into bits 19:15.
    logic [79:0] ky_rot;
    logic [79:0] ky_next;

    assign ky_rot  = {ky[18:0], ky[79:19]};
    assign ky_next = {sbox(ky_rot[79:76]), ky_rot[75:20],
                      ky_rot[19:15] ^ round_cnt, ky_rot[14:0]};

    assign bus.req_ready = (state == S_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.C         = c_q;
    assign busy          = (state == S_RUN) || (state == S_FINAL);

    // Sequencer: accept a job, iterate the rounds, add the final key, then
    // hold the result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the working state and key registers are cleared as well,
            // so an abandoned job leaves nothing behind that could resurface.
            state       <= S_IDLE;
            st          <= '0;
            ky          <= '0;
            c_q         <= '0;
            res_valid_q <= 1'b0;
            round_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments here let every register see the
            // values from before the edge, so st and ky update in lockstep.
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        st        <= bus.M;
                        ky        <= bus.K;
                        round_cnt <= 5'd1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    st <= st_next;
                    ky <= ky_next;
                    if (round_cnt == LAST_ROUND) begin
                        // Counter parks at ROUNDS rather than wrapping.
                        state <= S_FINAL;
                    end else begin
                        round_cnt <= round_cnt + 5'd1;
                    end
                end
                S_FINAL: begin
                    c_q         <= st ^ ky[79:16];
                    res_valid_q <= 1'b1;
                    state       <= S_DONE;
                end
                default: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        round_cnt   <= '0;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_seq.sv
// Self-checking bench for encrypt_seq: known-answer vectors, backpressure,
// ignored requests while busy, simultaneous handshakes, mid-job reset and
// back-to-back jobs checked against a behavioural cipher model.
module tb_encrypt_seq;

    localparam int ROUNDS = 31;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [4:0] round_cnt;

    encrypt_seq_if bus();

    encrypt_seq #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .round_cnt (round_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];

    // Behavioural cipher model (independent formulation of the permutation).
    function automatic logic [63:0] ref_enc(input logic [79:0] key, input logic [63:0] pt);
        logic [63:0] tbl;
        logic [63:0] s;
        logic [63:0] t;
        logic [79:0] k;
        tbl = 64'h21748FE3DA09B65C;
        s = pt;
        k = key;
        t = '0;
        for (int r = 1; r <= ROUNDS; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = tbl[4*int'(s[4*n +: 4]) +: 4];
            for (int j = 0; j < 64; j++) s[(j % 4)*16 + j/4] = t[j];
            k = {k[18:0], k[79:19]};
            k[79:76] = tbl[4*int'(k[79:76]) +: 4];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // Drives one job end to end and checks latency, busy, hold and result.
    task automatic run_job(input logic [79:0] k, input logic [63:0] m,
                           input logic [63:0] expc, input int hold,
                           input bit inject, input bit overlap, input string name);
        int          lat;
        int          bcnt;
        logic [63:0] held;
        logic [63:0] e;
        lat = 0;
        while (bus.req_ready !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s idle_wait: req_ready=%b expected 1", name, bus.req_ready);
        end
        bus.K = k; bus.M = m; bus.req_valid = 1'b1; bus.res_ready = (hold == 0);
        exp_q.push_back(expc);
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.K = ~k; bus.M = ~m;
        n_cmp++;
        if (round_cnt !== 5'd1 || bus.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL %s accept: round_cnt=%0d req_ready=%b expected 1/0", name, round_cnt, bus.req_ready);
        end
        bcnt = int'(busy);
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 100) begin
            if (inject && lat == 5) begin
                bus.req_valid = 1'b1; bus.K = 80'h0123456789ABCDEF0123; bus.M = 64'hDEADBEEFCAFEF00D;
            end
            if (inject && lat == 9) bus.req_valid = 1'b0;
            @(posedge clk); #1; lat++;
            bcnt += int'(busy);
        end
        n_cmp++;
        if (lat != ROUNDS + 1) begin
            n_bad++; $display("FAIL %s latency: got %0d cycles expected %0d", name, lat, ROUNDS + 1);
        end
        n_cmp++;
        if (bcnt != ROUNDS + 1) begin
            n_bad++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcnt, ROUNDS + 1);
        end
        held = bus.C;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.res_valid !== 1'b1 || bus.C !== held || bus.req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s hold[%0d]: res_valid=%b C=%h req_ready=%b expected 1/%h/0",
                         name, i, bus.res_valid, bus.C, bus.req_ready, held);
            end
        end
        bus.res_ready = 1'b1;
        bus.req_valid = overlap;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++; $display("FAIL %s scoreboard: result with empty queue C=%h", name, bus.C);
        end else begin
            e = exp_q.pop_front();
            if (bus.C !== e) begin
                n_bad++; $display("FAIL %s ciphertext: C=%h expected %h", name, bus.C, e);
            end
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1 || round_cnt !== 5'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s consume: res_valid=%b req_ready=%b round_cnt=%0d busy=%b expected 0/1/0/0",
                     name, bus.res_valid, bus.req_ready, round_cnt, busy);
        end
        n_cmp++;
        if (bus.C !== expc) begin
            n_bad++; $display("FAIL %s c_after_consume: C=%h expected %h", name, bus.C, expc);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_ctrl: req_ready=%b res_valid=%b busy=%b expected 1/0/0",
                              bus.req_ready, bus.res_valid, busy);
        end
        n_cmp++;
        if (bus.C !== 64'h0 || round_cnt !== 5'd0) begin
            n_bad++; $display("FAIL reset_data: C=%h round_cnt=%0d expected 0/0", bus.C, round_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_known_vectors();
        run_job(80'h0, 64'h0, 64'h5579C1387B228445, 0, 1'b0, 1'b0, "kat_zero_zero");
        run_job({80{1'b1}}, 64'h0, 64'hE72C46C0F5945049, 0, 1'b0, 1'b0, "kat_keyones");
    endtask

    task automatic test_simultaneous();
        run_job(80'h0, {64{1'b1}}, 64'hA112FFC72F68417B, 0, 1'b0, 1'b1, "done_overlap");
    endtask

    task automatic test_backpressure();
        run_job({80{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2, 10, 1'b0, 1'b0, "backpressure");
    endtask

    task automatic test_ignore_req();
        run_job(80'h0, 64'h0, 64'h5579C1387B228445, 0, 1'b1, 1'b0, "ignore_req");
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.K = 80'h13579BDF02468ACE1357; bus.M = 64'h0F1E2D3C4B5A6978; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (round_cnt !== 5'd15 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        n_cmp++;
        if (round_cnt !== 5'd15) begin
            n_bad++; $display("FAIL reset_mid_reach: round_cnt=%0d expected 15", round_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || busy !== 1'b0 ||
            bus.C !== 64'h0 || round_cnt !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: req_ready=%b res_valid=%b busy=%b C=%h round_cnt=%0d expected 1/0/0/0/0",
                     bus.req_ready, bus.res_valid, busy, bus.C, round_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(80'h0, 64'h0, 64'h5579C1387B228445, 0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [79:0] k;
        logic [63:0] m;
        for (int j = 0; j < 3; j++) begin
            k = {$urandom(), $urandom(), 16'($urandom())};
            m = {$urandom(), $urandom()};
            run_job(k, m, ref_enc(k, m), 0, 1'b0, 1'b0, "back_to_back");
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.K = '0;
        bus.M = '0;
        test_reset();
        test_known_vectors();
        test_simultaneous();
        test_backpressure();
        test_ignore_req();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
